// File: rtl/mai_pkg.sv
// Shared definitions for the memory access interface: field widths, burst length
// codes, response status codes and the responder state encoding.
package mai_pkg;

    localparam int ADDR_W   = 32;
    localparam int TAG_W    = 4;
    localparam int ID_W     = 3;
    localparam int LEN_W    = 2;
    localparam int QOS_W    = 4;
    localparam int DATA_W   = 32;
    localparam int MASK_W   = 4;
    localparam int STATUS_W = 2;

    localparam logic [LEN_W-1:0] LEN_1 = 2'b00;
    localparam logic [LEN_W-1:0] LEN_2 = 2'b01;
    localparam logic [LEN_W-1:0] LEN_4 = 2'b10;
    localparam logic [LEN_W-1:0] LEN_8 = 2'b11;

    localparam logic [STATUS_W-1:0] STATUS_OK     = 2'b00;
    localparam logic [STATUS_W-1:0] STATUS_DECERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_DATA  = 2'd1,
        ST_RD_FETCH = 2'd2,
        ST_RD_RESP  = 2'd3
    } state_e;

    function automatic logic [3:0] len_to_beats(input logic [LEN_W-1:0] len);
        return 4'd1 << len;
    endfunction

endpackage

// File: rtl/mac_sram.sv
// Single-port synchronous SRAM, 2^AW x 32, per-byte write enables, read data
// registered one cycle after the enabled access (read-before-write).
module mac_sram
    import mai_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic [MASK_W-1:0] we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [0:(1<<AW)-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (we[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_access_responder.sv
// Memory-side responder: arbitrates read/write headers in IDLE, streams write
// bursts into a local SRAM and returns read bursts on the response channel.
module mem_access_responder
    import mai_pkg::*;
#(
    parameter int AW          = 10,
    parameter bit WR_TIE_WINS = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iMAI_ValidRd,
    input  logic [ADDR_W-1:0]   iMAI_AddrRd,
    input  logic [TAG_W-1:0]    iMAI_TagRd,
    input  logic [ID_W-1:0]     iMAI_IdRd,
    input  logic [LEN_W-1:0]    iMAI_LenRd,
    input  logic [QOS_W-1:0]    iMAI_QoSRd,
    output logic                oMAI_ReadyRd,
    output logic                oMAI_ValidRsp,
    output logic [TAG_W-1:0]    oMAI_TagRsp,
    output logic [DATA_W-1:0]   oMAI_DataRsp,
    output logic [STATUS_W-1:0] oMAI_StatusRsp,
    output logic                oMAI_EoD,
    input  logic                iMAI_ReadyRsp,
    input  logic                iMAI_ValidWr,
    input  logic [ADDR_W-1:0]   iMAI_AddrWr,
    input  logic [TAG_W-1:0]    iMAI_TagWr,
    input  logic [ID_W-1:0]     iMAI_IdWr,
    input  logic [LEN_W-1:0]    iMAI_LenWr,
    input  logic [QOS_W-1:0]    iMAI_QoSWr,
    output logic                oMAI_ReadyWr,
    input  logic [DATA_W-1:0]   iMAI_DataWr,
    input  logic [MASK_W-1:0]   iMAI_MaskWr,
    input  logic                iMAI_EoD,
    output logic                oErr,
    output logic [1:0]          oDbgState
);

    // Handshake rule on every channel: a transfer happens on the rising edge where
    // Valid and Ready are both 1; the response side holds all fields while Ready=0.

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [3:0]        beats_q, beats_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              decerr_q, decerr_d;
    logic              err_q, err_d;

    logic              sram_en;
    logic [MASK_W-1:0] sram_we;
    logic [DATA_W-1:0] sram_rdata;
    logic              win_wr, win_rd, last_beat;

    logic unused_bits;
    assign unused_bits = ^{iMAI_IdRd, iMAI_IdWr, iMAI_TagWr, iMAI_AddrRd[1:0], iMAI_AddrWr[1:0]};

    function automatic logic is_decerr(input logic [ADDR_W-1:0] a);
        return (a >> (AW + 2)) != '0;
    endfunction

    // Arbitration winner; the loser simply sees Ready=0 and keeps its header.
    assign win_wr = iMAI_ValidWr &&
                    (!iMAI_ValidRd || (iMAI_QoSWr > iMAI_QoSRd) ||
                     ((iMAI_QoSWr == iMAI_QoSRd) && WR_TIE_WINS));
    assign win_rd = iMAI_ValidRd && !win_wr;

    assign oMAI_ReadyWr = (state_q == ST_IDLE) && win_wr;
    assign oMAI_ReadyRd = (state_q == ST_IDLE) && win_rd;

    assign last_beat = ({1'b0, cnt_q} == (beats_q - 4'd1));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        beats_d  = beats_q;
        cnt_d    = cnt_q;
        tag_d    = tag_q;
        decerr_d = decerr_q;
        err_d    = err_q;
        sram_en  = 1'b0;
        sram_we  = '0;
        case (state_q)
            ST_IDLE: begin
                if (oMAI_ReadyWr) begin
                    state_d  = ST_WR_DATA;
                    addr_d   = iMAI_AddrWr[AW+1:2];
                    beats_d  = len_to_beats(iMAI_LenWr);
                    cnt_d    = '0;
                    decerr_d = is_decerr(iMAI_AddrWr);
                    err_d    = err_q | is_decerr(iMAI_AddrWr);
                end else if (oMAI_ReadyRd) begin
                    state_d  = ST_RD_FETCH;
                    addr_d   = iMAI_AddrRd[AW+1:2];
                    beats_d  = len_to_beats(iMAI_LenRd);
                    cnt_d    = '0;
                    tag_d    = iMAI_TagRd;
                    decerr_d = is_decerr(iMAI_AddrRd);
                    err_d    = err_q | is_decerr(iMAI_AddrRd);
                end
            end
            ST_WR_DATA: begin
                sram_en = !decerr_q;
                sram_we = decerr_q ? '0 : iMAI_MaskWr;
                if (last_beat || iMAI_EoD) begin
                    // Early EoD and a missing EoD on the final beat are both protocol errors.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    err_d   = err_q | (last_beat != iMAI_EoD);
                end else begin
                    cnt_d  = cnt_q + 3'd1;
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_RD_FETCH: begin
                sram_en = 1'b1;
                state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (iMAI_ReadyRsp) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_RD_FETCH;
                        cnt_d   = cnt_q + 3'd1;
                        addr_d  = addr_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            beats_q  <= '0;
            cnt_q    <= '0;
            tag_q    <= '0;
            decerr_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            beats_q  <= beats_d;
            cnt_q    <= cnt_d;
            tag_q    <= tag_d;
            decerr_q <= decerr_d;
            err_q    <= err_d;
        end
    end

    mac_sram #(.AW(AW)) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .addr  (addr_q),
        .wdata (iMAI_DataWr),
        .rdata (sram_rdata)
    );

    // Response fields are all zero whenever no beat is being presented.
    assign oMAI_ValidRsp  = (state_q == ST_RD_RESP);
    assign oMAI_TagRsp    = oMAI_ValidRsp ? tag_q : '0;
    assign oMAI_DataRsp   = (oMAI_ValidRsp && !decerr_q) ? sram_rdata : '0;
    assign oMAI_StatusRsp = (oMAI_ValidRsp && decerr_q) ? STATUS_DECERR : STATUS_OK;
    assign oMAI_EoD       = oMAI_ValidRsp && last_beat;
    assign oErr           = err_q;
    assign oDbgState      = state_q;

endmodule

// File: doc/mem_access_responder.md
Name: mem_access_responder

Overview:
- Memory-side responder (the MAC end) for the read/write request protocol driven by the memory access interconnector.
- Accepts one read or write request header at a time, moves 1/2/4/8-beat bursts into or out of a local byte-maskable SRAM, and returns read data on the response channel with tags.
- Stands in for the external memory controller in subsystem simulation and small FPGA builds.

Parameters:
- AW, 10, word-address width; memory depth = 2^AW 32-bit words.
- WR_TIE_WINS, 1, on equal QoS in IDLE: 1 = write wins, 0 = read wins.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- iMAI_ValidRd  in  1  read header valid
- iMAI_AddrRd  in  32  read byte address
- iMAI_TagRd  in  4  read tag
- iMAI_IdRd  in  3  requester id (ignored)
- iMAI_LenRd  in  2  burst length code
- iMAI_QoSRd  in  4  read priority
- oMAI_ReadyRd  out  1  read header accepted
- oMAI_ValidRsp  out  1  response beat valid
- oMAI_TagRsp  out  4  echoed read tag
- oMAI_DataRsp  out  32  read data
- oMAI_StatusRsp  out  2  00 OK, 10 decode error
- oMAI_EoD  out  1  last response beat
- iMAI_ReadyRsp  in  1  response sink ready
- iMAI_ValidWr  in  1  write header valid
- iMAI_AddrWr  in  32  write byte address
- iMAI_TagWr, iMAI_IdWr, iMAI_LenWr, iMAI_QoSWr  in  4/3/2/4  write header fields
- oMAI_ReadyWr  out  1  write header accepted
- iMAI_DataWr  in  32  write data beat
- iMAI_MaskWr  in  4  byte enables, bit i = byte i
- iMAI_EoD  in  1  last write beat
- oErr  out  1  sticky protocol/decode error

Behaviour:
- Reset: all outputs 0, state IDLE, beat counter 0. Memory contents are not cleared. Reset mid-burst abandons the burst, with no partial response.
- Len decode: 00→1, 01→2, 10→4, 11→8 beats.
- Word address = Addr[AW+1:2]; Addr[1:0] ignored. Bursts increment the word address by 1, wrapping modulo 2^AW.
- Decode error when Addr[31:AW+2] != 0.
- FSM states: IDLE, WR_DATA, RD_FETCH, RD_RESP.
- IDLE, header acceptance:
  - ReadyRd/ReadyWr are Mealy outputs, asserted only in IDLE and only for the arbitration winner.
  - Only one valid: that one wins.
  - Both valid: higher QoS wins; tie resolved by WR_TIE_WINS.
  - A header is accepted in the cycle Valid&Ready=1. The loser is held off; its Ready stays 0.
- Write (IDLE→WR_DATA):
  - Latch address and beat count. Every cycle in WR_DATA is a data beat; there is no data back-pressure.
  - First beat arrives the cycle after header acceptance.
  - Each beat writes the bytes enabled by MaskWr to the current word. Decode-error bursts write nothing and set oErr.
  - Exit to IDLE after the final counted beat.
  - EoD on an earlier beat terminates the burst at that beat and sets oErr.
  - Final beat without EoD also sets oErr.
- Read (IDLE→RD_FETCH):
  - RD_FETCH: issue the SRAM read (1-cycle synchronous).
  - RD_RESP: present ValidRsp=1 with TagRsp, DataRsp, StatusRsp, and EoD=1 on the last beat. All are held stable while ReadyRsp=0.
  - On Valid&ReadyRsp: if beats remain, go to RD_FETCH with address+1; else go to IDLE.
  - First ValidRsp is 2 cycles after header acceptance; throughput is 1 beat per 2 cycles.
  - Decode error: every beat returns DataRsp=0, StatusRsp=10, and all beats are still returned; oErr is set.
- ValidRsp=0 outside RD_RESP. DataRsp/TagRsp/StatusRsp/EoD are 0 when ValidRsp=0.
- oErr clears only on reset.

Decomposition:
- Package mai_pkg:
  - LEN codes and a len-to-beats function
  - STATUS_OK / STATUS_DECERR
  - state encoding
  - field widths shared with the interconnector: ADDR 32, TAG 4, ID 3, LEN 2, QOS 4, DATA 32, MASK 4, STATUS 2
- Sub-module mac_sram: single-port synchronous RAM, 2^AW x 32, 4-bit byte write enables, 1-cycle read latency.

Test Plan:
- Write Addr=0x10, Len=01, Data 0xA5A5A5A5/0x12345678, Mask=F, EoD on beat 2; then read Addr=0x10, Len=01, Tag=3 → two beats, Tag 3, status 00, EoD on beat 2 only, oErr=0.
- Masked write: Mask=0001 with 0x000000FF over preloaded 0xFFFFFF00 → readback 0xFFFFFFFF.
- Read and write valid in the same IDLE cycle, QoSRd=5/QoSWr=2 → ReadyRd only; then QoS 3/3 with WR_TIE_WINS=1 → ReadyWr only.
- Read Len=11 with ReadyRsp toggling 1/0 → 8 beats, data held across stalls; last word at 2^AW-1 wraps to 0.
- Read Addr=0x8000_0000 → all beats status 10, data 0, oErr=1; write with EoD on beat 1 of Len=10 → return to IDLE next cycle, oErr=1.
- Assert reset during beat 3 of a 4-beat read → outputs 0 immediately; a new read after deassertion completes normally.
